instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/instr_fetch_pc_next.sv | 27 ++
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared FSM encodings and constants for the instruction fetch unit.
// Serves as the shared defines for instr_fetch and pc_next.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALTED
  } if_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection, increment and target alignment handling.
// IFETCH_ALIGN_CHECK_EN: flag unaligned targets instead of masking them.
module pc_next
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pc_sel,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misalign
);

  assign pc_plus4 = pc + 32'd4;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = pc_sel & (|branch_target[1:0]);
  assign next_pc  = pc_sel ? branch_target : pc_plus4;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target[1:0];
  assign misalign = 1'b0;
  assign next_pc  = pc_sel ? {branch_target[31:2], 2'b00}
                           : pc_plus4;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: REQ/WAIT/VALID handshake with imem.
// IFETCH_ALIGN_CHECK_EN: unaligned branch targets halt the fetch.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        PC_Sel,
  input  logic [31:0] Branch_Target,
  input  logic        Halt,
  input  logic        Instr_Ack,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Gnt,
  input  logic        Imem_Rvalid,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction,
  output logic        Instr_Valid,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        Halted,
  output logic        Fetch_Misalign,
  output logic [31:0] Retired_Count
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        mis_q, mis_d;
  logic [31:0] next_pc;
  logic        misalign;

  pc_next u_pc_next (
    .pc            (pc_q),
    .pc_sel        (PC_Sel),
    .branch_target (Branch_Target),
    .pc_plus4      (PC_Plus4),
    .next_pc       (next_pc),
    .misalign      (misalign)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    mis_d    = mis_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: if (Imem_Gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (Imem_Rvalid) begin
          state_d = S_VALID;
          instr_d = Imem_Rdata;
        end
      end
      S_VALID: begin
        if (Instr_Ack) begin
          cnt_d   = cnt_q + 32'd1;
          instr_d = NOP;
          if (Halt) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
          end else if (misalign) begin
            state_d  = S_HALTED;
            halted_d = 1'b1;
            mis_d    = 1'b1;
          end else begin
            state_d = S_REQ;
            pc_d    = next_pc;
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    // Handshake outputs are registered from the next state
    req_d   = (state_d == S_REQ);
    valid_d = (state_d == S_VALID);
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      instr_q  <= NOP;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      mis_q    <= mis_d;
    end
  end

  assign Imem_Req       = req_q;
  assign Imem_Addr      = pc_q;
  assign Instruction    = instr_q;
  assign Instr_Valid    = valid_q;
  assign PC             = pc_q;
  assign Halted         = halted_q;
  assign Fetch_Misalign = mis_q;
  assign Retired_Count  = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with RESET_VECTOR = 32'h100.
// Expected values are hand-computed constants.
module tb_instr_fetch;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        halt = 1'b0;
  logic        ack = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [31:0] instr;
  logic        ivalid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        halted;
  logic        misal;
  logic [31:0] rcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_VECTOR(RV)) u_dut (
    .Clk            (clk),
    .Rst_N          (rst_n),
    .PC_Sel         (pc_sel),
    .Branch_Target  (br_tgt),
    .Halt           (halt),
    .Instr_Ack      (ack),
    .Imem_Req       (req),
    .Imem_Addr      (addr),
    .Imem_Gnt       (gnt),
    .Imem_Rvalid    (rvalid),
    .Imem_Rdata     (rdata),
    .Instruction    (instr),
    .Instr_Valid    (ivalid),
    .PC             (pc),
    .PC_Plus4       (pc4),
    .Halted         (halted),
    .Fetch_Misalign (misal),
    .Retired_Count  (rcnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(ivalid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RV);
    chk("rst_cnt", rcnt, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_misal", 32'(misal), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Full REQ/WAIT/VALID transaction at expected address
  task automatic fetch(input string tag,
                       input logic [31:0] exp_addr,
                       input logic [31:0] data);
    int n = 0;
    while (!req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(req), 32'd1);
    chk({tag, "_addr"}, addr, exp_addr);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk({tag, "_wait_req"}, 32'(req), 32'd0);
    chk({tag, "_wait_nop"}, instr, NOP);
    rvalid = 1'b1;
    rdata  = data;
    @(negedge clk);
    rvalid = 1'b0;
    chk({tag, "_valid"}, 32'(ivalid), 32'd1);
    chk({tag, "_instr"}, instr, data);
    chk({tag, "_pc"}, pc, exp_addr);
  endtask

  task automatic do_ack(input logic h,
                        input logic sel,
                        input logic [31:0] tgt);
    halt   = h;
    pc_sel = sel;
    br_tgt = tgt;
    ack    = 1'b1;
    @(negedge clk);
    ack    = 1'b0;
    halt   = 1'b0;
    pc_sel = 1'b0;
  endtask

  initial begin
    do_reset();
    // Released at this negedge: IDLE now, REQ after next edge
    #1;
    chk("idle_req", 32'(req), 32'd0);
    @(negedge clk);
    chk("c1_req", 32'(req), 32'd1);
    chk("c1_addr", addr, RV);
    gnt    = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_0001;
    @(negedge clk);
    gnt    = 1'b0;
    chk("c2_wait_novalid", 32'(ivalid), 32'd0);
    rdata  = 32'h1111_0001;
    @(negedge clk);
    rvalid = 1'b0;
    chk("c3_valid", 32'(ivalid), 32'd1);
    chk("c3_instr", instr, 32'h1111_0001);
    chk("c3_pc4", pc4, 32'h104);

    // Ack held while valid and not... then branch to 0
    do_ack(1'b0, 1'b1, 32'h0);
    chk("cnt1", rcnt, 32'd1);
    ack = 1'b1;
    fetch("seq0", 32'h0, 32'h0000_0A01);
    ack = 1'b0;
    chk("ack_ignored_cnt", rcnt, 32'd1);
    chk("seq0_pc4", pc4, 32'h4);
    do_ack(1'b0, 1'b0, 32'h40);
    fetch("seq1", 32'h4, 32'h0000_0A02);
    do_ack(1'b0, 1'b0, 32'h40);
    fetch("seq2", 32'h8, 32'h0000_0A03);
    do_ack(1'b0, 1'b0, 32'h40);
    fetch("seq3", 32'hC, 32'h0000_0A04);
    chk("cnt4", rcnt, 32'd4);

    do_ack(1'b0, 1'b1, 32'h40);
    fetch("br", 32'h40, 32'h0000_0B01);

    do_ack(1'b0, 1'b1, 32'h42);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("mis_flag", 32'(misal), 32'd1);
    chk("mis_halted", 32'(halted), 32'd1);
    chk("mis_pc", pc, 32'h40);
    chk("mis_cnt", rcnt, 32'd6);
    repeat (3) @(negedge clk);
    chk("mis_noreq", 32'(req), 32'd0);
`else
    fetch("mis", 32'h40, 32'h0000_0B02);
    chk("mis_flag", 32'(misal), 32'd0);
    chk("mis_cnt", rcnt, 32'd6);
`endif

    // Reset while a request is outstanding in WAIT
    do_reset();
    @(negedge clk);
    chk("w_req", 32'(req), 32'd1);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("w_rst_req", 32'(req), 32'd0);
    chk("w_rst_pc", pc, RV);
    @(negedge clk);
    rst_n  = 1'b1;
    rvalid = 1'b1;
    rdata  = 32'hBAD0_BAD0;
    @(negedge clk);
    rvalid = 1'b0;
    chk("stale_valid", 32'(ivalid), 32'd0);
    chk("stale_instr", instr, NOP);
    fetch("after_rst", RV, 32'h0000_0C01);

    // PC+4 wraps at the top of the address space
    do_ack(1'b0, 1'b1, 32'hFFFF_FFFC);
    fetch("top", 32'hFFFF_FFFC, 32'h0000_0D01);
    chk("wrap_pc4", pc4, 32'h0);
    do_ack(1'b0, 1'b0, 32'h0);
    fetch("wrap", 32'h0, 32'h0000_0D02);
    chk("wrap_cnt", rcnt, 32'd2);

    do_ack(1'b1, 1'b0, 32'h0);
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_cnt", rcnt, 32'd3);
    begin
      int reqs = 0;
      int vals = 0;
      for (int i = 0; i < 20; i++) begin
        rvalid = 1'b1;
        ack    = 1'b1;
        @(negedge clk);
        reqs += int'(req);
        vals += int'(ivalid);
      end
      rvalid = 1'b0;
      ack    = 1'b0;
      chk("h_noreq", 32'(reqs), 32'd0);
      chk("h_novalid", 32'(vals), 32'd0);
    end
    chk("h_pc", pc, 32'h0);
    chk("h_instr", instr, NOP);
    chk("h_cnt_hold", rcnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
